passcode_entry: RTL and testbench

PASSCODE_ENTRY -- requirements
Module: passcode_entry

---
 rtl/doorlock_pkg.sv | 14 +
 rtl/passcode_entry_if.sv | 21 ++
 rtl/onehot_to_bcd.sv | 28 ++
 rtl/passcode_entry.sv | 164 ++++++++++++++++
 tb/tb_passcode_entry.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/doorlock_pkg.sv
// rtl/doorlock_pkg.sv - shared types and constants for the passcode entry block
package doorlock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;

  localparam int DEFAULT_CODE_LEN = 4;

endpackage

// File: rtl/passcode_entry_if.sv
// rtl/passcode_entry_if.sv - keypad inputs and door status outputs of the passcode block
interface passcode_entry_if;
  logic [9:0] key_in;
  logic       enter_in;
  logic       clear_in;
  logic       unlock;
  logic       fail_pulse;
  logic       locked_out;
  logic [2:0] digit_count;
  logic       key_err;

  modport master (
    output key_in, enter_in, clear_in,
    input  unlock, fail_pulse, locked_out, digit_count, key_err
  );

  modport slave (
    input  key_in, enter_in, clear_in,
    output unlock, fail_pulse, locked_out, digit_count, key_err
  );
endinterface

// File: rtl/onehot_to_bcd.sv
// rtl/onehot_to_bcd.sv - one-hot keypad vector to BCD digit with valid/error flags
module onehot_to_bcd
  import doorlock_pkg::*;
(
  input  logic [9:0] i_onehot,
  output digit_t     o_digit,
  output logic       o_valid,
  output logic       o_err
);

  logic [3:0] w_ones;

  // Count set bits and pick the index of the set bit (meaningful only when exactly one)
  always_comb begin
    w_ones  = '0;
    o_digit = '0;
    for (int k = 0; k < 10; k++) begin
      if (i_onehot[k]) begin
        w_ones  = w_ones + 4'd1;
        o_digit = 4'(k);
      end
    end
  end

  assign o_valid = (w_ones == 4'd1);
  assign o_err   = (w_ones > 4'd1);

endmodule

// File: rtl/passcode_entry.sv
// rtl/passcode_entry.sv - keypad passcode checker with unlock hold, lockout and idle clear
module passcode_entry
  import doorlock_pkg::*;
#(
  parameter int                    CODE_LEN      = DEFAULT_CODE_LEN,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE  = 16'h1234,
  parameter int                    MAX_FAIL      = 3,
  parameter int                    UNLOCK_CYCLES = 50_000_000,
  parameter int                    LOCK_CYCLES   = 250_000_000,
  parameter int                    IDLE_CYCLES   = 500_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  passcode_entry_if.slave   bus
);

  localparam int BUF_W    = 4 * CODE_LEN;
  localparam int UNLOCK_W = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  localparam int LOCK_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int IDLE_W   = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int FAIL_W   = $clog2(MAX_FAIL + 1);

  state_t              r_state;
  logic [BUF_W-1:0]    r_code;
  logic [BUF_W-1:0]    r_buf;
  logic [2:0]          r_digit_cnt;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic [UNLOCK_W-1:0] r_unlock_tmr;
  logic [LOCK_W-1:0]   r_lock_tmr;
  logic [IDLE_W-1:0]   r_idle_tmr;
  logic                r_unlock;
  logic                r_fail_pulse;
  logic                r_locked_out;
  logic                r_key_err;

  digit_t              w_digit;
  logic                w_key_valid;
  logic                w_key_err;
  logic                w_buf_full;
  logic                w_key_any;

  onehot_to_bcd u_dec (
    .i_onehot (bus.key_in),
    .o_digit  (w_digit),
    .o_valid  (w_key_valid),
    .o_err    (w_key_err)
  );

  assign w_buf_full = (r_digit_cnt == 3'(CODE_LEN));
  assign w_key_any  = (bus.key_in != '0);

  // Main controller: state, digit buffer, stored code, timers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ENTRY;
      r_code       <= DEFAULT_CODE;
      r_buf        <= '0;
      r_digit_cnt  <= '0;
      r_fail_cnt   <= '0;
      r_unlock_tmr <= '0;
      r_lock_tmr   <= '0;
      r_idle_tmr   <= '0;
      r_unlock     <= 1'b0;
      r_fail_pulse <= 1'b0;
      r_locked_out <= 1'b0;
      r_key_err    <= 1'b0;
    end else begin
      r_fail_pulse <= 1'b0;
      r_key_err    <= w_key_err;
      case (r_state)
        ST_ENTRY: begin
          if (bus.clear_in) begin
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_idle_tmr  <= '0;
          end else if (bus.enter_in) begin
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_idle_tmr  <= '0;
            if (w_buf_full && (r_buf == r_code)) begin
              r_state      <= ST_UNLOCKED;
              r_unlock     <= 1'b1;
              r_fail_cnt   <= '0;
              r_unlock_tmr <= '0;
            end else begin
              r_fail_pulse <= 1'b1;
              if (r_fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
                r_state      <= ST_LOCKOUT;
                r_locked_out <= 1'b1;
                r_fail_cnt   <= '0;
                r_lock_tmr   <= '0;
              end else begin
                r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
              end
            end
          end else if (w_key_any) begin
            // Any key activity, even a rejected one, restarts the inactivity window
            r_idle_tmr <= '0;
            if (w_key_valid && !w_buf_full) begin
              r_buf       <= {r_buf[BUF_W-5:0], w_digit};
              r_digit_cnt <= r_digit_cnt + 3'd1;
            end
          end else if (r_digit_cnt != 3'd0) begin
            if (r_idle_tmr == IDLE_W'(IDLE_CYCLES - 1)) begin
              r_buf       <= '0;
              r_digit_cnt <= '0;
              r_idle_tmr  <= '0;
            end else begin
              r_idle_tmr <= r_idle_tmr + IDLE_W'(1);
            end
          end
        end

        ST_UNLOCKED: begin
          if (!bus.clear_in && bus.enter_in && w_buf_full) begin
            // Code change: store the new code and give a fresh unlock window
            r_code       <= r_buf;
            r_buf        <= '0;
            r_digit_cnt  <= '0;
            r_unlock_tmr <= '0;
          end else if (r_unlock_tmr == UNLOCK_W'(UNLOCK_CYCLES - 1)) begin
            r_state     <= ST_ENTRY;
            r_unlock    <= 1'b0;
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_idle_tmr  <= '0;
          end else begin
            r_unlock_tmr <= r_unlock_tmr + UNLOCK_W'(1);
            if (bus.clear_in) begin
              r_buf       <= '0;
              r_digit_cnt <= '0;
            end else if (!bus.enter_in && w_key_valid && !w_buf_full) begin
              r_buf       <= {r_buf[BUF_W-5:0], w_digit};
              r_digit_cnt <= r_digit_cnt + 3'd1;
            end
          end
        end

        ST_LOCKOUT: begin
          r_buf       <= '0;
          r_digit_cnt <= '0;
          if (r_lock_tmr == LOCK_W'(LOCK_CYCLES - 1)) begin
            r_state      <= ST_ENTRY;
            r_locked_out <= 1'b0;
            r_idle_tmr   <= '0;
          end else begin
            r_lock_tmr <= r_lock_tmr + LOCK_W'(1);
          end
        end

        default: begin
          r_state <= ST_ENTRY;
        end
      endcase
    end
  end

  assign bus.unlock      = r_unlock;
  assign bus.fail_pulse  = r_fail_pulse;
  assign bus.locked_out  = r_locked_out;
  assign bus.digit_count = r_digit_cnt;
  assign bus.key_err     = r_key_err;

endmodule

// File: tb/tb_passcode_entry.sv
// tb/tb_passcode_entry.sv - self-checking bench for passcode_entry
module tb_passcode_entry;

  localparam int UNLOCK_CYC = 20;
  localparam int LOCK_CYC   = 30;
  localparam int IDLE_CYC   = 40;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   hi;

  passcode_entry_if bus ();

  passcode_entry #(
    .CODE_LEN      (4),
    .DEFAULT_CODE  (16'h1234),
    .MAX_FAIL      (3),
    .UNLOCK_CYCLES (UNLOCK_CYC),
    .LOCK_CYCLES   (LOCK_CYC),
    .IDLE_CYCLES   (IDLE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] key;
    logic       enter;
    logic       clear;
    logic       unl;
    logic       fp;
    logic       lo;
    logic [2:0] cnt;
    logic       ke;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [9:0] k, input logic e, input logic c);
    @(negedge clk);
    bus.key_in   = k;
    bus.enter_in = e;
    bus.clear_in = c;
    @(posedge clk);
    #1;
    bus.key_in   = '0;
    bus.enter_in = 1'b0;
    bus.clear_in = 1'b0;
  endtask

  function automatic logic [9:0] oh(input int d);
    logic [9:0] v;
    v = 10'd1;
    return v << d;
  endfunction

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) begin
      step(oh(int'(code[4*i +: 4])), 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n        = 1'b0;
    bus.key_in   = '0;
    bus.enter_in = 1'b0;
    bus.clear_in = 1'b0;

    //               key               en    clr   unl   fp    lo    cnt   ke
    vecs[0]  = '{10'd0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{10'b0000000110,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    vecs[2]  = '{10'd0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{oh(1),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[4]  = '{oh(2),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
    vecs[5]  = '{oh(3),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0};
    vecs[6]  = '{oh(4),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[7]  = '{oh(5),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[8]  = '{10'd0,           1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{oh(1),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[10] = '{oh(2),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
    vecs[11] = '{oh(3),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0};
    vecs[12] = '{oh(4),           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[13] = '{oh(5),           1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};

    #2;
    chk("rst_unlock", int'(bus.unlock), 0);
    chk("rst_locked", int'(bus.locked_out), 0);
    chk("rst_count", int'(bus.digit_count), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: reset idle, bad key, saturation, clear+enter, key dropped with enter
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].key, vecs[i].enter, vecs[i].clear);
      chk($sformatf("v%0d_unlock", i), int'(bus.unlock), int'(vecs[i].unl));
      chk($sformatf("v%0d_fail", i), int'(bus.fail_pulse), int'(vecs[i].fp));
      chk($sformatf("v%0d_locked", i), int'(bus.locked_out), int'(vecs[i].lo));
      chk($sformatf("v%0d_count", i), int'(bus.digit_count), int'(vecs[i].cnt));
      chk($sformatf("v%0d_keyerr", i), int'(bus.key_err), int'(vecs[i].ke));
    end

    // Unlock held for exactly UNLOCK_CYC cycles
    hi = 1;
    for (int i = 0; i < 100; i++) begin
      step('0, 1'b0, 1'b0);
      if (bus.unlock) hi++;
      else break;
    end
    chk("unlock_len", hi, UNLOCK_CYC);

    // Three wrong codes: fail pulses, lockout on the third
    for (int r = 0; r < 3; r++) begin
      enter_code(16'h1235);
      step('0, 1'b1, 1'b0);
      chk($sformatf("wrong%0d_fail", r), int'(bus.fail_pulse), 1);
      chk($sformatf("wrong%0d_locked", r), int'(bus.locked_out), (r == 2) ? 1 : 0);
      if (r < 2) begin
        step('0, 1'b0, 1'b0);
        chk($sformatf("wrong%0d_fail_drop", r), int'(bus.fail_pulse), 0);
      end
    end
    hi = 1;
    enter_code(16'h1234);
    hi += 4;
    chk("lock_keys_ignored", int'(bus.digit_count), 0);
    step('0, 1'b1, 1'b0);
    if (bus.locked_out) hi++;
    chk("lock_enter_unlock", int'(bus.unlock), 0);
    chk("lock_enter_fail", int'(bus.fail_pulse), 0);
    for (int i = 0; i < 100; i++) begin
      step('0, 1'b0, 1'b0);
      if (bus.locked_out) hi++;
      else break;
    end
    chk("lock_len", hi, LOCK_CYC);

    // Idle timeout clears the buffer but keeps the fail counter
    enter_code(16'h1111);
    step('0, 1'b1, 1'b0);
    chk("idle_pre_fail", int'(bus.fail_pulse), 1);
    step(oh(1), 1'b0, 1'b0);
    chk("idle_key", int'(bus.digit_count), 1);
    repeat (IDLE_CYC - 1) step('0, 1'b0, 1'b0);
    chk("idle_before", int'(bus.digit_count), 1);
    step('0, 1'b0, 1'b0);
    chk("idle_cleared", int'(bus.digit_count), 0);
    step('0, 1'b1, 1'b0);
    chk("kept_fail2_locked", int'(bus.locked_out), 0);
    step('0, 1'b1, 1'b0);
    chk("kept_fail3_locked", int'(bus.locked_out), 1);
    for (int i = 0; i < 100; i++) begin
      step('0, 1'b0, 1'b0);
      if (!bus.locked_out) break;
    end
    chk("lock2_released", int'(bus.locked_out), 0);

    // Code change while unlocked restarts the window; old code then fails
    enter_code(16'h1234);
    step('0, 1'b1, 1'b0);
    chk("chg_unlock", int'(bus.unlock), 1);
    enter_code(16'h9876);
    chk("chg_count", int'(bus.digit_count), 4);
    step('0, 1'b1, 1'b0);
    chk("chg_store_unlock", int'(bus.unlock), 1);
    chk("chg_store_count", int'(bus.digit_count), 0);
    hi = 1;
    for (int i = 0; i < 100; i++) begin
      step('0, 1'b0, 1'b0);
      if (bus.unlock) hi++;
      else break;
    end
    chk("chg_restart_len", hi, UNLOCK_CYC);
    enter_code(16'h1234);
    step('0, 1'b1, 1'b0);
    chk("old_code_fail", int'(bus.fail_pulse), 1);
    chk("old_code_unlock", int'(bus.unlock), 0);
    enter_code(16'h9876);
    step('0, 1'b1, 1'b0);
    chk("new_code_unlock", int'(bus.unlock), 1);

    // Reset mid-unlock drops unlock at once and restores the default code
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_unlock", int'(bus.unlock), 0);
    @(negedge clk);
    rst_n = 1'b1;
    enter_code(16'h1234);
    step('0, 1'b1, 1'b0);
    chk("rst_default_unlock", int'(bus.unlock), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
